// File: rtl/serial_tx.sv
// serial_tx: frames a parallel word as start bit, DATA_W data bits LSB first, stop bit
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              txd,
   output logic              busy,
   output logic              done
);
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;
   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              bit_end;
   // handshake and status follow the state directly so din_ready is always !busy
   always_comb begin
      bit_end   = cnt == C_LAST;
      busy      = state != IDLE;
      din_ready = state == IDLE;
   end
   // frame sequencer; txd is registered and loaded one edge ahead of each symbol
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (din_valid) begin
               shreg <= din;
               state <= START;
               txd   <= 1'b0;
            end
            START: if (bit_end) begin
               state   <= DATA;
               txd     <= shreg[0];
               shreg   <= shreg >> 1;
               bit_cnt <= '0;
            end
            DATA: if (bit_end) begin
               if (bit_cnt == B_LAST) begin
                  state   <= STOP;
                  txd     <= 1'b1;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
            default: if (bit_end) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frames on two serializer instances (4 and 1 clocks per bit) against a frame-position model
module tb_serial_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] dn [2];
   logic       dv [2];
   logic       txd_o [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       rdy_o [2];
   int         checks = 0;
   int         errors = 0;
   logic       act [2];
   int         pos [2];
   logic [7:0] wd [2];
   logic       de [2];
   logic       seen = 1'b0;

   always #5 clk = ~clk;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
      .clk(clk), .rst(rst), .din(dn[0]), .din_valid(dv[0]), .din_ready(rdy_o[0]),
      .txd(txd_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .din(dn[1]), .din_valid(dv[1]), .din_ready(rdy_o[1]),
      .txd(txd_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   // model: a frame is 10 symbols of cpb cycles each; position within the frame picks the symbol
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int cpb;
         cpb = i ? 1 : 4;
         if (!rst) begin
            act[i] = 1'b0;
            de[i]  = 1'b0;
         end else begin
            de[i] = 1'b0;
            if (act[i]) begin
               pos[i]++;
               if (pos[i] == 10 * cpb) begin
                  act[i] = 1'b0;
                  de[i]  = 1'b1;
               end
            end else if (dv[i]) begin
               act[i] = 1'b1;
               pos[i] = 0;
               wd[i]  = dn[i];
            end
         end
      end
      if (!rst) seen = 1'b1;
      #1;
      if (seen) begin
         for (int i = 0; i < 2; i++) begin
            int   cpb;
            logic et;
            cpb = i ? 1 : 4;
            et  = !act[i] ? 1'b1 : pos[i] < cpb ? 1'b0 : pos[i] < 9 * cpb ? wd[i][pos[i] / cpb - 1] : 1'b1;
            chk($sformatf("model txd inst%0d", i), txd_o[i], et);
            chk($sformatf("model busy inst%0d", i), busy_o[i], act[i]);
            chk($sformatf("model ready inst%0d", i), rdy_o[i], !act[i]);
            chk($sformatf("model done inst%0d", i), done_o[i], de[i]);
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : sva
      a_done_idle: assert property (@(posedge clk) disable iff (!rst) done_o[g] |-> !busy_o[g])
         else begin errors++; $display("FAIL sva done_not_busy inst%0d", g); end
      a_idle_high: assert property (@(posedge clk) disable iff (!rst) !busy_o[g] |-> txd_o[g])
         else begin errors++; $display("FAIL sva idle_txd_high inst%0d", g); end
      a_ready: assert property (@(posedge clk) disable iff (!rst) rdy_o[g] == !busy_o[g])
         else begin errors++; $display("FAIL sva ready_is_not_busy inst%0d", g); end
      a_pulse: assert property (@(posedge clk) disable iff (!rst) done_o[g] |=> !done_o[g])
         else begin errors++; $display("FAIL sva done_single inst%0d", g); end
   end

   task automatic send(input int i, input logic [7:0] w);
      dn[i] = w;
      dv[i] = 1'b1;
      @(negedge clk);
      dv[i] = 1'b0;
      dn[i] = ~w;
   endtask

   task automatic frame(input int i, input int cpb, input logic [9:0] exp, input string nm);
      logic [9:0] sy;
      int         bc;
      int         rc;
      sy = '0;
      bc = 0;
      rc = 0;
      for (int k = 0; k < 10 * cpb; k++) begin
         if (k % cpb == 0) sy = {sy[8:0], txd_o[i]};
         bc += int'(busy_o[i]);
         rc += int'(rdy_o[i]);
         @(negedge clk);
      end
      chk({nm, " symbols"}, sy, exp);
      chk({nm, " busy cycles"}, bc, 10 * cpb);
      chk({nm, " ready cycles"}, rc, 0);
      chk({nm, " done"}, done_o[i], 1);
      chk({nm, " done ready"}, rdy_o[i], 1);
      chk({nm, " done txd"}, txd_o[i], 1);
   endtask

   initial begin
      dv[0] = 1'b0;
      dv[1] = 1'b0;
      dn[0] = 8'h00;
      dn[1] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset txd", txd_o[0], 1);
      chk("reset busy", busy_o[0], 0);
      chk("reset ready", rdy_o[0], 1);
      chk("reset done", done_o[0], 0);
      rst = 1'b1;
      @(negedge clk);
      send(0, 8'hA5);
      frame(0, 4, 10'b0101001011, "A5");
      @(negedge clk);
      chk("A5 done width", done_o[0], 0);
      dn[0] = 8'h00;
      dv[0] = 1'b1;
      @(negedge clk);
      dn[0] = 8'hFF;
      frame(0, 4, 10'b0000000001, "00");
      @(negedge clk);
      dv[0] = 1'b0;
      frame(0, 4, 10'b0111111111, "FF");
      @(negedge clk);
      send(0, 8'h81);
      fork
         frame(0, 4, 10'b0100000011, "81");
         begin
            repeat (10) @(negedge clk);
            dn[0] = 8'h3C;
            dv[0] = 1'b1;
            @(negedge clk);
            dv[0] = 1'b0;
         end
      join
      @(negedge clk);
      chk("3C ignored busy", busy_o[0], 0);
      send(0, 8'h55);
      repeat (17) @(negedge clk);
      rst   = 1'b0;
      dv[0] = 1'b1;
      dn[0] = 8'h77;
      @(negedge clk);
      chk("abort txd", txd_o[0], 1);
      chk("abort busy", busy_o[0], 0);
      chk("abort ready", rdy_o[0], 1);
      chk("abort done", done_o[0], 0);
      @(negedge clk);
      chk("reset ignores valid", busy_o[0], 0);
      dv[0] = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      chk("post abort done", done_o[0], 0);
      chk("post abort busy", busy_o[0], 0);
      send(0, 8'h0F);
      frame(0, 4, 10'b0111100001, "0F");
      @(negedge clk);
      send(1, 8'hC3);
      frame(1, 1, 10'b0110000111, "C3");
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
